// File: rtl/operand_mux_pkg.sv
// Shared defaults, select-width helper and buffer occupancy encoding for operand_mux_pipe.
package operand_mux_pkg;

   localparam int OPERAND_W_DEFAULT = 32;
   localparam int NUM_IN_DEFAULT    = 4;

   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_t;

endpackage

// File: rtl/operand_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready is registered so out_ready never reaches it combinationally.
module operand_skid_buf
   import operand_mux_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   buf_state_t        state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              ready_q, ready_d;
   logic              accept, pop;

   assign accept    = in_valid && ready_q;
   assign pop       = (state_q != BUF_EMPTY) && out_ready;
   assign in_ready  = ready_q;
   assign out_valid = (state_q != BUF_EMPTY);
   assign out_data  = main_q;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         BUF_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (pop && accept) begin
               main_d = in_data;
            end else if (pop) begin
               state_d = BUF_EMPTY;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = BUF_FULL;
            end
         end
         BUF_FULL: begin
            // ready_q is low here, so only a pop can change anything
            if (pop) begin
               main_d  = skid_q;
               state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
      ready_d = (state_d != BUF_FULL);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         // NOTE: payload registers are reset too, because the visible output must read zero after reset.
         state_q <= BUF_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= ready_d;
      end
   end

endmodule

// File: rtl/operand_mux_pipe.sv
// Operand selector feeding a 2-entry skid buffer; OPERAND_MUX_PARITY_EN adds a stored out_parity output.
module operand_mux_pipe
   import operand_mux_pkg::*;
#(
   parameter int WIDTH  = OPERAND_W_DEFAULT,
   parameter int NUM_IN = NUM_IN_DEFAULT,
   parameter int SEL_W  = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_operands,
   input  logic [SEL_W-1:0]        in_select,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_operand,
   output logic                    out_sel_err,
   output logic                    out_valid,
`ifdef OPERAND_MUX_PARITY_EN
   output logic                    out_parity,
`endif
   input  logic                    out_ready
);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             sel_err;
`ifdef OPERAND_MUX_PARITY_EN
      logic             parity;
`endif
   } operand_item_t;

   localparam int ITEM_W = $bits(operand_item_t);

   operand_item_t     sel_item, out_item;
   logic [ITEM_W-1:0] buf_in, buf_out;

   always_comb begin
      sel_item         = '0;
      sel_item.sel_err = (int'(in_select) >= NUM_IN);
      // out-of-range selects fall back to operand 0 with the error flag set
      sel_item.data    = in_operands[WIDTH-1:0];
      for (int k = 1; k < NUM_IN; k++) begin
         if (int'(in_select) == k) begin
            sel_item.data = in_operands[k*WIDTH +: WIDTH];
         end
      end
`ifdef OPERAND_MUX_PARITY_EN
      sel_item.parity = ^sel_item.data;
`endif
   end

   assign buf_in   = sel_item;
   assign out_item = buf_out;

   operand_skid_buf #(
      .DATA_W (ITEM_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (buf_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (buf_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_operand = out_item.data;
   assign out_sel_err = out_item.sel_err;
`ifdef OPERAND_MUX_PARITY_EN
   assign out_parity  = out_item.parity;
`endif

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Scoreboard bench for operand_mux_pipe (NUM_IN=5); define OPERAND_MUX_PARITY_EN to also check out_parity.
module tb_operand_mux_pipe;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 5;
   localparam int SEL_W  = 3;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_IN*WIDTH-1:0] in_operands;
   logic [SEL_W-1:0]        in_select;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_operand;
   logic                    out_sel_err;
   logic                    out_valid;
   logic                    out_ready;
`ifdef OPERAND_MUX_PARITY_EN
   logic                    out_parity;
`endif

   logic [WIDTH-1:0] ops [NUM_IN];

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             err;
      logic             par;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   last_acc;

   operand_mux_pipe #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_operands (in_operands),
      .in_select   (in_select),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_operand (out_operand),
      .out_sel_err (out_sel_err),
      .out_valid   (out_valid),
`ifdef OPERAND_MUX_PARITY_EN
      .out_parity  (out_parity),
`endif
      .out_ready   (out_ready)
   );

   initial forever #5 clk = ~clk;

   always_comb begin
      in_operands = '0;
      for (int k = 0; k < NUM_IN; k++) in_operands[k*WIDTH +: WIDTH] = ops[k];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the selected operand, or operand 0 flagged as an error when out of range.
   function automatic exp_t model(input int sel);
      exp_t e;
      if (sel >= NUM_IN) begin
         e.data = ops[0];
         e.err  = 1'b1;
      end else begin
         e.data = ops[sel];
         e.err  = 1'b0;
      end
      e.par = ^e.data;
      return e;
   endfunction

   // One clock: record an input transfer at the negedge before the edge that performs it.
   task automatic step();
      @(negedge clk);
      last_acc = (rst_n === 1'b1) && (in_valid === 1'b1) && (in_ready === 1'b1);
      if (last_acc) sb_q.push_back(model(int'(in_select)));
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int sel);
      in_valid  = 1'b1;
      in_select = SEL_W'(sel);
      last_acc  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (last_acc) break;
      end
      if (!last_acc) check("send_timeout", 64'(last_acc), 64'd1);
   endtask

   // Monitor: pops on every output transfer and checks that stalled outputs hold.
   initial begin
      exp_t e;
      exp_t held;
      bit   stall = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (stall) begin
               check("hold_valid", 64'(out_valid), 64'd1);
               check("hold_data", 64'(out_operand), 64'(held.data));
               check("hold_err", 64'(out_sel_err), 64'(held.err));
`ifdef OPERAND_MUX_PARITY_EN
               check("hold_parity", 64'(out_parity), 64'(held.par));
`endif
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_out", 64'(out_valid), 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("sb_data", 64'(out_operand), 64'(e.data));
                  check("sb_err", 64'(out_sel_err), 64'(e.err));
`ifdef OPERAND_MUX_PARITY_EN
                  check("sb_parity", 64'(out_parity), 64'(e.par));
`endif
               end
            end
            stall     = (out_valid === 1'b1) && (out_ready === 1'b0);
            held.data = out_operand;
            held.err  = out_sel_err;
`ifdef OPERAND_MUX_PARITY_EN
            held.par  = out_parity;
`else
            held.par  = 1'b0;
`endif
         end else begin
            stall = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_select = '0;
      out_ready = 1'b1;
      for (int k = 0; k < NUM_IN; k++) ops[k] = WIDTH'(k) * 32'h1111_1111;

      // Reset held for three edges with in_valid asserted
      repeat (3) begin
         step();
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_out_operand", 64'(out_operand), 64'd0);
         check("rst_in_ready", 64'(in_ready), 64'd0);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      step();
      check("rel_in_ready", 64'(in_ready), 64'd1);
      check("rel_out_valid", 64'(out_valid), 64'd0);

      // Back-to-back selects 3,2,1,0 with no backpressure
      send(3);
      check("lat_valid", 64'(out_valid), 64'd1);
      check("basic_3", 64'(out_operand), 64'h3333_3333);
      send(2);
      check("basic_2", 64'(out_operand), 64'h2222_2222);
      send(1);
      check("basic_1", 64'(out_operand), 64'h1111_1111);
      send(0);
      check("basic_0", 64'(out_operand), 64'h0);
      in_valid = 1'b0;
      step();
      check("basic_drained", 64'(out_valid), 64'd0);

      // Backpressure fills main then skid
      out_ready = 1'b0;
      send(1);
      send(2);
      in_valid = 1'b0;
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_main", 64'(out_operand), 64'h1111_1111);
      repeat (2) step();
      out_ready = 1'b1;
      step();
      check("bp_in_ready_back", 64'(in_ready), 64'd1);
      check("bp_second", 64'(out_operand), 64'h2222_2222);
      step();
      check("bp_drained", 64'(out_valid), 64'd0);

      // Out-of-range select falls back to operand 0
      ops[0] = 32'hA5A5_0F0F;
      send(6);
      check("oor_data", 64'(out_operand), 64'hA5A5_0F0F);
      check("oor_err", 64'(out_sel_err), 64'd1);
      send(4);
      check("sel4_data", 64'(out_operand), 64'h4444_4444);
      check("sel4_err", 64'(out_sel_err), 64'd0);
      in_valid = 1'b0;
      step();

      // Reset while both entries are full
      out_ready = 1'b0;
      send(1);
      send(2);
      in_valid = 1'b0;
      check("mid_full", 64'(in_ready), 64'd0);
      rst_n = 1'b0;
      sb_q.delete();
      step();
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) step();
      check("mid_no_stale", 64'(out_valid), 64'd0);
      check("mid_in_ready", 64'(in_ready), 64'd1);

`ifdef OPERAND_MUX_PARITY_EN
      ops[1]    = 32'h0000_0007;
      ops[2]    = 32'h0000_0003;
      out_ready = 1'b0;
      send(1);
      in_valid  = 1'b0;
      check("par_odd", 64'(out_parity), 64'd1);
      step();
      check("par_held", 64'(out_parity), 64'd1);
      out_ready = 1'b1;
      step();
      send(2);
      in_valid = 1'b0;
      check("par_even", 64'(out_parity), 64'd0);
      step();
`endif

      // Randomised traffic including out-of-range selects and operand changes between transfers
      repeat (400) begin
         for (int k = 0; k < NUM_IN; k++) ops[k] = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_select = SEL_W'($urandom_range(0, 7));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (sb_q.size() == 0) break;
         step();
      end
      check("drain_empty", 64'(sb_q.size()), 64'd0);
      step();
      check("drain_out_valid", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
